// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add MUL/MULH and restoring DIV/REM,
// one iteration per cycle on magnitudes, with the sign applied on the way to DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  state_t state, next_state;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    div_zero, div_ovf;
  logic                    accept_calc, accept_fast, finish;
  logic [WIDTH-1:0]        fast_result;

  // Latched operation: magnitudes, signs and the shared hi/lo accumulator
  logic [1:0]       op_q;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]     sum, rem_shift, diff, hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   calc_result;

  assign a_s      = opA;
  assign b_s      = opB;
  assign div_zero = (opB == '0);
  assign div_ovf  = (opA == MOST_NEG) && (opB == '1);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept_calc = 1'b0;
    accept_fast = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (op[1] && (div_zero || div_ovf)) begin
            accept_fast = 1'b1;
            next_state  = DONE;
          end else begin
            accept_calc = 1'b1;
            next_state  = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          next_state = IDLE;
        end else if (cnt == LAST) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fast_result = '0;
    if (div_zero) fast_result = (op == OP_DIV) ? '1 : opA;
    else          fast_result = (op == OP_DIV) ? MOST_NEG : '0;
  end

  assign busy  = (state == CALC);
  assign done  = (state == DONE);
  assign stall = rst && (((state == IDLE) && start) || (state == CALC));

  // One radix-2 step: MUL shifts {hi,lo} right after a conditional add,
  // DIV shifts the dividend into hi and keeps the difference when it does not borrow.
  always_comb begin
    sum       = lo[0] ? (hi + {1'b0, mag}) : hi;
    rem_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff      = rem_shift - {1'b0, mag};
    if (op_q[1]) begin
      if (diff[WIDTH]) begin
        hi_next = rem_shift;
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_next = diff;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_next = {1'b0, sum[WIDTH:1]};
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_signed = apply_sign_wide({hi_next[WIDTH-1:0], lo_next}, sign_a ^ sign_b);
    case (op_q)
      OP_MUL:  calc_result = prod_signed[WIDTH-1:0];
      OP_MULH: calc_result = prod_signed[2*WIDTH-1:WIDTH];
      OP_DIV:  calc_result = apply_sign(lo_next, sign_a ^ sign_b);
      default: calc_result = apply_sign(hi_next[WIDTH-1:0],
                                        sign_a && (hi_next[WIDTH-1:0] != '0));
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      result <= '0;
    end else begin
      if (accept_calc)          cnt <= '0;
      else if (state == CALC)   cnt <= cnt + CW'(1);
      if (accept_fast)          result <= fast_result;
      else if (finish)          result <= calc_result;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_calc) begin
      op_q   <= op;
      sign_a <= opA[WIDTH-1];
      sign_b <= opB[WIDTH-1];
      hi     <= '0;
      if (op[1]) begin
        mag <= abs_val(b_s);
        lo  <= abs_val(a_s);
      end else begin
        mag <= abs_val(a_s);
        lo  <= abs_val(b_s);
      end
    end else if (state == CALC) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: directed cases, special divides,
// flush/reset aborts, held start and a short random run against a behavioural model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;
  localparam logic [1:0] OP_MUL = 2'b00, OP_MULH = 2'b01, OP_DIV = 2'b10, OP_REM = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         flush = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic         stall, busy, done;
  logic [W-1:0] result;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .opA(opA), .opB(opB), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [63:0] pa, pb, prod;
    int sa, sb;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    prod = pa * pb;
    sa = a;
    sb = b;
    case (o)
      OP_MUL:  return prod[31:0];
      OP_MULH: return prod[63:32];
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input int lat, input string name);
    int k;
    bit seen;
    logic [W-1:0] want;
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    exp_q.push_back(exp_r);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL %s.stall_req got=%b want=1", name, stall); end
    @(negedge clk);
    start = 1'b0; opA = $urandom; opB = $urandom;
    k = 1; seen = 0;
    while (!seen && k <= W + 8) begin
      #1;
      if (done === 1'b1) begin
        seen = 1;
        total++;
        if (k != lat) begin bad++; $display("FAIL %s.latency got=%0d want=%0d", name, k, lat); end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (result !== want) begin
          bad++; $display("FAIL %s.result got=%h want=%h", name, result, want);
        end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL %s.stall_done got=%b want=0", name, stall); end
      end else begin
        total++;
        if (stall !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL %s.calc k=%0d got stall=%b busy=%b want 1/1", name, k, stall, busy);
        end
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s.timeout got no done want done at %0d", name, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; op = OP_MUL; opA = 32'd3; opB = 32'd4;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (stall !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL reset got stall=%b done=%b busy=%b result=%h want 0/0/0/0",
               stall, done, busy, result);
    end
    start = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_idle got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_mul();
    run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT, "mul_neg");
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || result !== 32'hFFFFFFEB) begin
      bad++; $display("FAIL mul_hold got done=%b result=%h want 0/ffffffeb", done, result);
    end
    run_op(OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, LAT, "mulh_minmin");
    run_op(OP_MUL,  32'h80000000, 32'h80000000, 32'h00000000, LAT, "mul_minmin");
    run_op(OP_MULH, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, LAT, "mulh_neg1");
    run_op(OP_MUL,  32'd12345, 32'd6789, 32'd83810205, LAT, "mul_pos");
  endtask

  task automatic test_div_rem();
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT, "div_neg7_2");
    run_op(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT, "rem_neg7_2");
    run_op(OP_DIV, 32'd100, 32'd7, 32'd14, LAT, "div_100_7");
    run_op(OP_REM, 32'd100, 32'd7, 32'd2, LAT, "rem_100_7");
    run_op(OP_REM, 32'hFFFFFFF8, 32'd2, 32'd0, LAT, "rem_zero_negdividend");
    run_op(OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, LAT, "div_100_neg7");
  endtask

  task automatic test_fast_path();
    run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_by_zero");
    run_op(OP_REM, 32'd5, 32'd0, 32'd5, 1, "rem_by_zero");
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");
  endtask

  task automatic test_flush();
    logic [W-1:0] prev;
    int dones;
    @(negedge clk);
    prev = result;
    start = 1'b1; flush = 1'b1; op = OP_DIV; opA = 32'd100; opB = 32'd7;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL flush_start got busy=%b done=%b want 0/0", busy, done);
    end
    @(negedge clk);
    start = 1'b1; op = OP_DIV; opA = 32'd100; opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL flush_precalc got busy=%b want 1", busy); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
      bad++;
      $display("FAIL flush_abort got busy=%b done=%b result=%h want 0/0/%h", busy, done, result, prev);
    end
    dones = 0;
    repeat (40) begin @(negedge clk); #1; if (done === 1'b1) dones++; end
    total++;
    if (dones != 0) begin bad++; $display("FAIL flush_quiet got dones=%0d want 0", dones); end
    run_op(OP_DIV, 32'd100, 32'd7, 32'd14, LAT, "flush_recover");
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    start = 1'b1; op = OP_MULH; opA = 32'h12345678; opB = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk); #1;
    total++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got result=%h done=%b busy=%b stall=%b want 0/0/0/0",
               result, done, busy, stall);
    end
    rst = 1'b1; start = 1'b0;
    dones = 0;
    repeat (40) begin @(negedge clk); #1; if (done === 1'b1) dones++; end
    total++;
    if (dones != 0) begin bad++; $display("FAIL reset_quiet got dones=%0d want 0", dones); end
    run_op(OP_MULH, 32'h12345678, 32'h9ABCDEF0,
           ref_model(OP_MULH, 32'h12345678, 32'h9ABCDEF0), LAT, "reset_recover");
  endtask

  task automatic test_start_held();
    int k, dones;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; opA = 32'd3; opB = 32'd5;
    @(negedge clk);
    k = 1; seen = 0;
    while (!seen && k <= W + 8) begin
      op = 2'($urandom); opA = $urandom; opB = $urandom;
      #1;
      if (done === 1'b1) begin
        seen = 1;
        start = 1'b0;
        total++;
        if (k != LAT || result !== 32'd15) begin
          bad++; $display("FAIL held_start got k=%0d result=%h want %0d/0000000f", k, result, LAT);
        end
      end else begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL held_start.timeout got no done want done"); end
    dones = 0;
    repeat (40) begin @(negedge clk); #1; if (done === 1'b1 || busy === 1'b1) dones++; end
    total++;
    if (dones != 0) begin bad++; $display("FAIL held_quiet got activity=%0d want 0", dones); end
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [W-1:0] a, b;
    int lat;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = 32'($urandom_range(0, 9));
      if (i % 4 == 1) b = -32'($urandom_range(1, 9));
      lat = (o[1] && (b == 0 || (a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : LAT;
      run_op(o, a, b, ref_model(o, a, b), lat, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_rem();
    test_fast_path();
    test_flush();
    test_reset_mid();
    test_start_held();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and at least 4.
REQ-002 SHALL derive localparam CW = $clog2(WIDTH), the iteration counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request operation; sampled only in IDLE.
REQ-006 SHALL have port op  input  2  operation: 00 MUL (low half), 01 MULH (signed x signed, high half), 10 DIV (signed), 11 REM (signed).
REQ-007 SHALL have port flush  input  1  abort the current operation.
REQ-008 SHALL have port opA  input  WIDTH  multiplicand or dividend.
REQ-009 SHALL have port opB  input  WIDTH  multiplier or divisor.
REQ-010 SHALL have port stall  output  1  holds the pipeline EXE stage while the operation is incomplete.
REQ-011 SHALL have port busy  output  1  high in CALC.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL have port result  output  WIDTH  operation result.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-015 IDLE with start=1 and flush=0: latch op, |opA|, |opB| and the operand signs; clear the counter; go to CALC.
REQ-016 IDLE with start=1, op=DIV/REM and opB=0, or with opA=most-negative and opB=all-ones: latch the special result and go directly to DONE, skipping CALC.
REQ-017 CALC: perform exactly one radix-2 iteration per cycle (shift-add for MUL/MULH, restoring subtract for DIV/REM) and increment the counter.
REQ-018 CALC: after the iteration with counter = WIDTH-1, apply sign correction and go to DONE.
REQ-019 DONE: drive done=1 and the final result; go to IDLE on the next edge unconditionally.
REQ-020 Latency: start accepted at edge t; done high in cycle t+WIDTH+1. Fast path (REQ-016): done high in cycle t+1.
REQ-021 stall = (IDLE and start) or CALC; stall SHALL be 0 in DONE so the pipeline advances in the same cycle that done is high.
REQ-022 busy SHALL be 1 only in CALC.
REQ-023 MUL result SHALL be the low WIDTH bits of the 2*WIDTH product; these bits are the same for signed and unsigned operands.
REQ-024 MULH result SHALL be the high WIDTH bits of the signed 2*WIDTH product.
REQ-025 DIV SHALL truncate toward zero.
REQ-026 The REM result sign SHALL follow the dividend; a zero remainder is never negated.
REQ-027 Divide by zero: DIV result = all ones; REM result = opA.
REQ-028 Overflow (most-negative / -1): DIV result = most-negative; REM result = 0.
REQ-029 result SHALL hold its last value until the next DONE; it SHALL NOT change in IDLE or CALC.
REQ-030 start in CALC or DONE SHALL be ignored; the operand latches and the counter SHALL be unaffected.
REQ-031 flush=1 in any state SHALL return the FSM to IDLE at the next edge with no done pulse; result is unchanged.
REQ-032 flush and start both high in IDLE: flush wins and nothing is accepted.
REQ-033 opA/opB changes after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-034 rst=0 at a clock edge SHALL force IDLE, counter=0, result=0, done=0, busy=0.
REQ-035 stall SHALL be 0 while rst=0, regardless of start.
REQ-036 rst=0 during CALC SHALL abort the operation with no done pulse; operation resumes only by a new start after rst returns to 1.

Verification (WIDTH=32)
REQ-037 MUL opA=7, opB=0xFFFFFFFD, start at edge t -> stall high t..t+WIDTH; done=1 with result=0xFFFFFFEB exactly in cycle t+33; stall=0 in that cycle.
REQ-038 MULH opA=opB=0x80000000 -> result=0x40000000; MUL with the same operands -> 0x00000000.
REQ-039 DIV opA=0xFFFFFFF9 (-7), opB=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIV 100/7 -> 14; REM 100/7 -> 2.
REQ-040 DIV opA=5, opB=0 -> 0xFFFFFFFF with done in cycle t+1; REM opA=5, opB=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-041 flush pulsed when the counter reaches 10 -> IDLE next cycle, no done, result keeps its prior value; the next start completes normally.
REQ-042 rst=0 mid-CALC -> result=0, done=0, busy=0, stall=0 next cycle; start held high in CALC or DONE -> no second operation until IDLE.
